// File: rtl/sysid_boot_checker.sv
// Boot-time system-ID checker: reads the sysid slave (ID, timestamp),
// compares both words with the expected image and reports pass/fail.
//
// Ports:
//   clock, reset_n       clock, asynchronous active-low reset
//   start                request a (re)check; honoured in IDLE/DONE only
//   avm_address/read     Avalon-MM master request towards the sysid slave
//   avm_waitrequest      slave stall
//   avm_readdata         slave read data
//   busy, done, pass     status; pass is meaningful while done=1
//   id_/ts_mismatch      last attempt's compare results
//   timeout_err          last attempt aborted by a stalled read
//   id_value, ts_value   last captured words
//   attempts             passes performed in the current/last check
module sysid_boot_checker #(
    parameter logic [31:0] EXPECTED_ID  = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS  = 32'h5A2F_5323,
    parameter int          TIMEOUT      = 255,
    parameter int          MAX_ATTEMPTS = 3,
    parameter int          AUTO_START   = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_mismatch,
    output logic        ts_mismatch,
    output logic        timeout_err,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic [7:0]  attempts
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ID,
        S_RD_TS,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [15:0] TO_LIM   = 16'(TIMEOUT);
    localparam logic [7:0]  ATT_LIM  = 8'(MAX_ATTEMPTS);
    localparam logic        AUTO_GO  = (AUTO_START != 0);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  attempts_q, attempts_d;
    logic [31:0] id_value_q, id_value_d;
    logic [31:0] ts_value_q, ts_value_d;
    logic        id_mis_q, id_mis_d;
    logic        ts_mis_q, ts_mis_d;
    logic        to_q, to_d;
    logic        pass_q, pass_d;
    // High only in the first cycle after reset release; drives auto-start.
    logic        first_q, first_d;

    logic        id_bad;
    logic        ts_bad;
    logic        any_err;

    assign id_bad  = (id_value_q != EXPECTED_ID);
    assign ts_bad  = (ts_value_q != EXPECTED_TS);
    assign any_err = id_bad | ts_bad | to_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        attempts_d = attempts_q;
        id_value_d = id_value_q;
        ts_value_d = ts_value_q;
        id_mis_d   = id_mis_q;
        ts_mis_d   = ts_mis_q;
        to_d       = to_q;
        pass_d     = pass_q;
        first_d    = 1'b0;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start || (first_q && AUTO_GO)) begin
                    state_d    = S_RD_ID;
                    cnt_d      = '0;
                    attempts_d = 8'd1;
                    id_mis_d   = 1'b0;
                    ts_mis_d   = 1'b0;
                    to_d       = 1'b0;
                    pass_d     = 1'b0;
                end
            end
            S_RD_ID: begin
                if (!avm_waitrequest) begin
                    id_value_d = avm_readdata;
                    cnt_d      = '0;
                    state_d    = S_RD_TS;
                end else if (cnt_q == TO_LIM) begin
                    // Timestamp read is skipped; its word stays stale.
                    to_d    = 1'b1;
                    state_d = S_CHECK;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_RD_TS: begin
                if (!avm_waitrequest) begin
                    ts_value_d = avm_readdata;
                    state_d    = S_CHECK;
                end else if (cnt_q == TO_LIM) begin
                    to_d    = 1'b1;
                    state_d = S_CHECK;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_CHECK: begin
                id_mis_d = id_bad;
                ts_mis_d = ts_bad;
                if (!any_err) begin
                    pass_d  = 1'b1;
                    state_d = S_DONE;
                end else if (attempts_q < ATT_LIM) begin
                    attempts_d = attempts_q + 8'd1;
                    to_d       = 1'b0;
                    cnt_d      = '0;
                    state_d    = S_RD_ID;
                end else begin
                    pass_d  = 1'b0;
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            attempts_q <= '0;
            id_value_q <= '0;
            ts_value_q <= '0;
            id_mis_q   <= 1'b0;
            ts_mis_q   <= 1'b0;
            to_q       <= 1'b0;
            pass_q     <= 1'b0;
            first_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            attempts_q <= attempts_d;
            id_value_q <= id_value_d;
            ts_value_q <= ts_value_d;
            id_mis_q   <= id_mis_d;
            ts_mis_q   <= ts_mis_d;
            to_q       <= to_d;
            pass_q     <= pass_d;
            first_q    <= first_d;
        end
    end

    // Bus strobes decode straight from the state flop, so reset drops
    // an in-flight read without waiting for a clock edge.
    assign avm_read    = (state_q == S_RD_ID) || (state_q == S_RD_TS);
    assign avm_address = (state_q == S_RD_TS);
    assign busy        = avm_read || (state_q == S_CHECK);
    assign done        = (state_q == S_DONE);
    assign pass        = pass_q;
    assign id_mismatch = id_mis_q;
    assign ts_mismatch = ts_mis_q;
    assign timeout_err = to_q;
    assign id_value    = id_value_q;
    assign ts_value    = ts_value_q;
    assign attempts    = attempts_q;

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Testbench for sysid_boot_checker: scripted/random Avalon slave plus
// an attempt-level reference model of the check outcome and timing.
module tb_sysid_boot_checker;

    localparam logic [31:0] EXP_ID = 32'h0000_0000;
    localparam logic [31:0] EXP_TS = 32'h5A2F_5323;
    localparam int          TO     = 4;
    localparam int          MAXA   = 3;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic        avm_address;
    logic        avm_read;
    logic        waitreq;
    logic [31:0] rdata;
    logic        busy, done, pass;
    logic        idm, tsm, to_err;
    logic [31:0] id_value, ts_value;
    logic [7:0]  attempts;

    logic        start_b;
    logic        addr_b, read_b;
    logic [31:0] rdata_b;
    logic        busy_b, done_b, pass_b;
    logic        idm_b, tsm_b, to_b;
    logic [31:0] idv_b, tsv_b;
    logic [7:0]  att_b;

    sysid_boot_checker #(
        .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS),
        .TIMEOUT(TO), .MAX_ATTEMPTS(MAXA), .AUTO_START(1)
    ) dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .avm_address(avm_address), .avm_read(avm_read),
        .avm_waitrequest(waitreq), .avm_readdata(rdata),
        .busy(busy), .done(done), .pass(pass),
        .id_mismatch(idm), .ts_mismatch(tsm), .timeout_err(to_err),
        .id_value(id_value), .ts_value(ts_value), .attempts(attempts)
    );

    sysid_boot_checker #(
        .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS),
        .TIMEOUT(TO), .MAX_ATTEMPTS(1), .AUTO_START(0)
    ) dut_b (
        .clock(clock), .reset_n(reset_n), .start(start_b),
        .avm_address(addr_b), .avm_read(read_b),
        .avm_waitrequest(1'b0), .avm_readdata(rdata_b),
        .busy(busy_b), .done(done_b), .pass(pass_b),
        .id_mismatch(idm_b), .ts_mismatch(tsm_b), .timeout_err(to_b),
        .id_value(idv_b), .ts_value(tsv_b), .attempts(att_b)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // Slave script: per-address queues of (stall cycles, data).
    int          id_s[$], ts_s[$];
    logic [31:0] id_d[$], ts_d[$];
    int          viol = 0;
    int          underrun = 0;

    initial begin
        bit          active;
        bit          act_addr;
        int          rem;
        logic [31:0] dat;
        active   = 0;
        act_addr = 0;
        rem      = 0;
        dat      = '0;
        waitreq  = 1'b0;
        rdata    = '0;
        rdata_b  = '0;
        forever begin
            @(negedge clock);
            if (!avm_read) begin
                active  = 0;
                waitreq = 1'b0;
            end else begin
                if (!active) begin
                    active   = 1;
                    act_addr = avm_address;
                    if (!avm_address && id_s.size() > 0) begin
                        rem = id_s.pop_front();
                        dat = id_d.pop_front();
                    end else if (avm_address && ts_s.size() > 0) begin
                        rem = ts_s.pop_front();
                        dat = ts_d.pop_front();
                    end else begin
                        underrun++;
                        rem = 0;
                        dat = '0;
                    end
                end else if (avm_address != act_addr) begin
                    viol++;
                end
                if (rem > 0) begin
                    waitreq = 1'b1;
                    rdata   = $urandom;
                    rem--;
                end else begin
                    waitreq = 1'b0;
                    rdata   = dat;
                    active  = 0;
                end
            end
            rdata_b = addr_b ? EXP_TS : EXP_ID;
        end
    end

    // Reference model state: captured words persist across checks.
    logic [31:0] m_id = '0, m_ts = '0;
    int exp_cyc, exp_rd, exp_att;
    bit exp_pass, exp_idm, exp_tsm, exp_to;

    task automatic gen(input int mode, input int att, input bit word,
                       output int s, output logic [31:0] d);
        logic [31:0] good;
        good = word ? EXP_TS : EXP_ID;
        s = 0;
        d = good;
        case (mode)
            0: begin
                s = ($urandom_range(0, 7) == 0) ?
                    5 + $urandom_range(0, 3) : $urandom_range(0, 2);
                if ($urandom_range(0, 3) == 0) d = $urandom;
            end
            2: if (!word) d = 32'h1;
            3: if (word && att == 1) d = EXP_TS ^ 32'h1;
            4: s = 1000;
            5: if (word) s = 2;
            default: ;
        endcase
    endtask

    // Builds the slave script for one whole check and predicts its result.
    task automatic plan(input int mode);
        int          s;
        logic [31:0] d;
        bit          tmo, err;
        exp_cyc = 0;
        exp_rd  = 0;
        exp_att = 0;
        err     = 1;
        while (err && exp_att < MAXA) begin
            exp_att++;
            tmo = 0;
            gen(mode, exp_att, 1'b0, s, d);
            id_s.push_back(s);
            id_d.push_back(d);
            if (s > TO) begin
                tmo = 1;
                exp_rd += TO + 1;
            end else begin
                exp_rd += s + 1;
                m_id = d;
            end
            if (!tmo) begin
                gen(mode, exp_att, 1'b1, s, d);
                ts_s.push_back(s);
                ts_d.push_back(d);
                if (s > TO) begin
                    tmo = 1;
                    exp_rd += TO + 1;
                end else begin
                    exp_rd += s + 1;
                    m_ts = d;
                end
            end
            exp_idm = (m_id != EXP_ID);
            exp_tsm = (m_ts != EXP_TS);
            exp_to  = tmo;
            err     = exp_idm || exp_tsm || tmo;
        end
        exp_cyc  = exp_rd + exp_att;
        exp_pass = !err;
    endtask

    task automatic run_check(input bit do_start, input bit poke);
        int n;
        int rd;
        if (do_start) begin
            @(negedge clock);
            start = 1'b1;
        end
        @(negedge clock);
        start = 1'b0;
        n  = 1;
        rd = 0;
        chk("busy_c1", {busy, done}, 2'b10);
        while (!done && n < 200) begin
            if (avm_read) rd++;
            start = (poke && n == 2);
            @(negedge clock);
            n++;
        end
        start = 1'b0;
        chk("done_cyc", n, exp_cyc + 1);
        chk("rd_cycles", rd, exp_rd);
        chk("busy_done", busy, 0);
        chk("pass", pass, exp_pass);
        chk("flags", {idm, tsm, to_err}, {exp_idm, exp_tsm, exp_to});
        chk("attempts", attempts, exp_att);
        chk("id_value", id_value, m_id);
        chk("ts_value", ts_value, m_ts);
        repeat (2) @(negedge clock);
        chk("done_hold", {done, pass, idm, tsm, to_err},
            {1'b1, exp_pass, exp_idm, exp_tsm, exp_to});
        chk("script_left", id_s.size() + ts_s.size(), 0);
    endtask

    task automatic chk_zero(input string tag, input logic [63:0] v);
        chk(tag, v, 64'd0);
    endtask

    initial begin
        int n;
        reset_n = 1'b0;
        start   = 1'b0;
        start_b = 1'b0;
        #1;
        chk_zero("rst_a_ctl", {avm_read, avm_address, busy, done, pass,
                               idm, tsm, to_err, attempts});
        chk_zero("rst_a_val", {id_value, ts_value});
        chk_zero("rst_b_ctl", {read_b, addr_b, busy_b, done_b, pass_b,
                               idm_b, tsm_b, to_b, att_b});
        repeat (3) @(negedge clock);

        plan(1);
        reset_n = 1'b1;
        run_check(1'b0, 1'b0);

        plan(2);
        run_check(1'b1, 1'b0);
        plan(3);
        run_check(1'b1, 1'b0);
        plan(4);
        run_check(1'b1, 1'b0);
        plan(5);
        run_check(1'b1, 1'b1);
        for (int i = 0; i < 30; i++) begin
            plan(0);
            run_check(1'b1, ($urandom_range(0, 1) == 1));
        end

        // Reset while the timestamp read is stalled.
        id_s.push_back(0);
        id_d.push_back(EXP_ID);
        ts_s.push_back(1000);
        ts_d.push_back(EXP_TS);
        @(negedge clock);
        start = 1'b1;
        repeat (3) begin
            @(negedge clock);
            start = 1'b0;
        end
        chk("pre_rst", {avm_read, avm_address, waitreq}, 3'b111);
        reset_n = 1'b0;
        #1;
        chk_zero("mid_rst_ctl", {avm_read, avm_address, busy, done, pass,
                                 idm, tsm, to_err, attempts});
        chk_zero("mid_rst_val", {id_value, ts_value});
        repeat (3) @(negedge clock);
        id_s.delete();
        id_d.delete();
        ts_s.delete();
        ts_d.delete();
        m_id = '0;
        m_ts = '0;
        plan(1);
        reset_n = 1'b1;
        run_check(1'b0, 1'b0);

        chk("b_idle", {read_b, busy_b, done_b, att_b}, 0);
        @(negedge clock);
        start_b = 1'b1;
        @(negedge clock);
        start_b = 1'b0;
        n = 1;
        while (!done_b && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk("b_done_cyc", n, 4);
        chk("b_result", {pass_b, idm_b, tsm_b, to_b, att_b},
            {4'b1000, 8'd1});

        chk("addr_stable", viol, 0);
        chk("underrun", underrun, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
